spi_mem_cache: RTL and testbench
================================

SPI_MEM_CACHE -- requirements
Module: spi_mem_cache

Interface
REQ-001 SHALL have parameter INDEX_BITS, default 4: log2 of the number of direct-mapped one-word lines; legal range 2..8.
REQ-002 SHALL have port clk, input, 1: the single clock; all state changes on the rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have ports cpu_valid (in, 1), cpu_ready (out, 1), cpu_addr (in, 23, word address), cpu_wdata (in, 32), cpu_wstrb (in, 4, 0 = read), cpu_rdata (out, 32).
REQ-005 SHALL have ports mem_valid (out, 1), mem_ready (in, 1), mem_addr (out, 23), mem_wdata (out, 32), mem_wstrb (out, 4), mem_rdata (in, 32), facing the quad-SPI PSRAM controller.
REQ-006 SHALL have port flush, input, 1: when high, invalidates all lines.

Function
REQ-007 SHALL split cpu_addr into index = cpu_addr[INDEX_BITS-1:0] and tag = cpu_addr[22:INDEX_BITS]; each line holds a valid bit, a tag and a 32-bit word, all in flops.
REQ-008 SHALL implement states IDLE, MEM_REQ, MEM_DRAIN and RESP.
REQ-009 IDLE: accept a request when cpu_valid=1 and cpu_ready=0; read hit -> cpu_rdata=line word, cpu_ready=1 on the next edge, stay IDLE (1-cycle latency).
REQ-010 IDLE: read miss or any write -> on the next edge mem_valid=1 and mem_addr/mem_wdata/mem_wstrb=cpu_addr/cpu_wdata/cpu_wstrb, enter MEM_REQ.
REQ-011 MEM_REQ: SHALL hold mem_valid and mem_* stable until mem_ready=1; on that edge: mem_valid=0, cpu_rdata=mem_rdata (reads only), enter MEM_DRAIN.
REQ-012 MEM_DRAIN: SHALL keep mem_valid=0 until mem_ready=0, then enter RESP; a new mem_valid SHALL never be raised while mem_ready=1.
REQ-013 RESP: SHALL pulse cpu_ready=1 for exactly one cycle, then return to IDLE.
REQ-014 cpu_ready SHALL always be a single-cycle pulse; after a pulse, a request is accepted only once cpu_valid has been sampled with cpu_ready=0.
REQ-015 A read miss SHALL fill its line (valid=1, tag, word=mem_rdata) on the mem_ready edge.
REQ-016 Writes SHALL be write-through and no-allocate; a write miss leaves the cache unchanged.
REQ-017 A write hit SHALL merge each byte lane whose cpu_wstrb bit is set into the line word; lanes with a clear bit are unchanged; the line stays valid.
REQ-018 flush=1 SHALL clear every valid bit on that edge; a fill or write merge on the same edge SHALL be suppressed. The in-flight CPU response SHALL still complete with the memory data.
REQ-019 A flush in IDLE with cpu_valid=1 SHALL cause that request to be treated as a miss.
REQ-020 cpu_rdata SHALL hold its last value between responses; it is undefined for write responses.

Reset
REQ-021 With reset=1 at an edge: state=IDLE, all valid bits=0, cpu_ready=0, mem_valid=0, cpu_rdata=0, mem_addr/mem_wdata/mem_wstrb=0, counters=0.
REQ-022 Reset mid-transaction SHALL abort it: mem_valid drops on that edge and no cpu_ready pulse follows. Tag and data arrays need no reset.

Configuration
REQ-023 Macro SPI_MEM_CACHE_STATS_EN defined: SHALL add outputs hit_count[31:0] and miss_count[31:0]. These count accepted read hits and read misses, increment one cycle after acceptance, and wrap modulo 2^32.
REQ-024 Macro SPI_MEM_CACHE_STATS_EN undefined: SHALL omit both ports and their counters; all other behaviour is identical.

Verification
REQ-025 Scenario: read 0x000005 (miss), memory model returns 0xDEADBEEF after 20 cycles -> one mem transaction; cpu_rdata=0xDEADBEEF; a repeat read hits with cpu_ready 1 cycle after acceptance and mem_valid stays 0.
REQ-026 Scenario: after REQ-025, write wstrb=0010, wdata=0x0000AA00 to 0x000005 -> mem_wstrb=0010 passed through; a following read hits and returns 0xDEADAAEF.
REQ-027 Scenario: read 0x000005, then read 0x000015 (same index, INDEX_BITS=4), then read 0x000005 -> three misses; line evicted each time.
REQ-028 Scenario: flush asserted on the mem_ready edge of a read miss -> cpu_rdata is correct, the next read of that address misses.
REQ-029 Scenario: mem_ready held high 3 cycles after the handshake -> mem_valid stays 0 until mem_ready falls; cpu_ready pulses once.
REQ-030 Scenario: reset while in MEM_REQ -> mem_valid=0 on that edge, no cpu_ready, all lines invalid. With SPI_MEM_CACHE_STATS_EN, the prior hit/miss counts return to 0.

Source files
------------

// File: rtl/spi_mem_cache.sv
// spi_mem_cache -- direct-mapped, one-word-per-line read cache between a CPU
// port and a quad-SPI PSRAM controller. Writes go through to memory and do
// not allocate; a write that hits merges its enabled bytes into the line.
//
// Ports:
//   clk, reset            single clock, synchronous active-high reset
//   cpu_valid/cpu_ready   CPU request / single-cycle completion pulse
//   cpu_addr [22:0]       word address; cpu_wdata/cpu_wstrb (0 = read)
//   cpu_rdata [31:0]      read data, held between responses
//   mem_valid/mem_ready   request/handshake towards the PSRAM controller
//   mem_addr/mem_wdata/mem_wstrb/mem_rdata   memory-side payload
//   flush                 invalidates every line on the edge it is high
//   hit_count/miss_count  read hit/miss counters, only present when the
//                         macro SPI_MEM_CACHE_STATS_EN is defined
module spi_mem_cache #(
    parameter int INDEX_BITS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_valid,
    output logic        cpu_ready,
    input  logic [22:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_wstrb,
    output logic [31:0] cpu_rdata,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [22:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
`ifdef SPI_MEM_CACHE_STATS_EN
    output logic [31:0] hit_count,
    output logic [31:0] miss_count,
`endif
    input  logic        flush
);
    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = 23 - INDEX_BITS;

    typedef enum logic [1:0] {IDLE, MEM_REQ, MEM_DRAIN, RESP} state_t;

    state_t state_q, state_d;

    logic [LINES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [31:0]      data_q [LINES];

    logic        cpu_ready_q, cpu_ready_d;
    logic [31:0] cpu_rdata_q, cpu_rdata_d;
    logic        mem_valid_q, mem_valid_d;
    logic [22:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_wstrb_q, mem_wstrb_d;

    // Lookup for the incoming CPU request and for the in-flight memory request
    logic [INDEX_BITS-1:0] cpu_idx, mem_idx;
    logic [TAG_W-1:0]      cpu_tag, mem_tag;
    logic                  cpu_hit, mem_hit, cpu_is_read, mem_is_read;
    logic                  accept, rd_hit, fill_en;
    logic [31:0]           line_word;

    assign cpu_idx     = cpu_addr[INDEX_BITS-1:0];
    assign cpu_tag     = cpu_addr[22:INDEX_BITS];
    assign mem_idx     = mem_addr_q[INDEX_BITS-1:0];
    assign mem_tag     = mem_addr_q[22:INDEX_BITS];
    assign cpu_is_read = (cpu_wstrb == 4'b0000);
    assign mem_is_read = (mem_wstrb_q == 4'b0000);

    // A flush on the accepting edge forces a miss so no stale word is returned
    assign cpu_hit = valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag) && !flush;
    assign mem_hit = valid_q[mem_idx] && (tag_q[mem_idx] == mem_tag);

    // cpu_ready_q gating keeps a held cpu_valid from being re-accepted right
    // after its own completion pulse
    assign accept = (state_q == IDLE) && cpu_valid && !cpu_ready_q;
    assign rd_hit = accept && cpu_is_read && cpu_hit;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (accept && !rd_hit) state_d = MEM_REQ;
            MEM_REQ:   if (mem_ready)         state_d = MEM_DRAIN;
            MEM_DRAIN: if (!mem_ready)        state_d = RESP;
            RESP:                             state_d = IDLE;
            default:                          state_d = IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        cpu_ready_d = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        mem_valid_d = mem_valid_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        fill_en     = 1'b0;

        // Read fills take the memory word; write hits merge enabled bytes
        line_word = mem_rdata;
        if (!mem_is_read) begin
            line_word = data_q[mem_idx];
            for (int b = 0; b < 4; b++)
                if (mem_wstrb_q[b]) line_word[b*8 +: 8] = mem_wdata_q[b*8 +: 8];
        end

        case (state_q)
            IDLE: begin
                if (rd_hit) begin
                    cpu_rdata_d = data_q[cpu_idx];
                    cpu_ready_d = 1'b1;
                end else if (accept) begin
                    mem_valid_d = 1'b1;
                    mem_addr_d  = cpu_addr;
                    mem_wdata_d = cpu_wdata;
                    mem_wstrb_d = cpu_wstrb;
                end
            end
            MEM_REQ: begin
                if (mem_ready) begin
                    mem_valid_d = 1'b0;
                    if (mem_is_read) cpu_rdata_d = mem_rdata;
                    // Write misses do not allocate; flush wins over any update
                    fill_en = !flush && (mem_is_read || mem_hit);
                end
            end
            MEM_DRAIN: if (!mem_ready) cpu_ready_d = 1'b1;
            default: ;
        endcase

        valid_d = flush ? '0 : valid_q;
        if (fill_en) valid_d[mem_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q     <= '0;
            cpu_ready_q <= 1'b0;
            cpu_rdata_q <= '0;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
        end else begin
            valid_q     <= valid_d;
            cpu_ready_q <= cpu_ready_d;
            cpu_rdata_q <= cpu_rdata_d;
            mem_valid_q <= mem_valid_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
        end
    end

    // Tag/data arrays carry no reset; valid_q alone qualifies them
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_q[mem_idx]  <= mem_tag;
            data_q[mem_idx] <= line_word;
        end
    end

    assign cpu_ready = cpu_ready_q;
    assign cpu_rdata = cpu_rdata_q;
    assign mem_valid = mem_valid_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;

`ifdef SPI_MEM_CACHE_STATS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (rd_hit)                            hit_cnt_q  <= hit_cnt_q + 32'd1;
            if (accept && cpu_is_read && !cpu_hit) miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_spi_mem_cache.sv
// Self-checking bench for spi_mem_cache: a behavioural PSRAM responder with
// adjustable latency / ready-hold, and a scoreboard of expected CPU responses
// popped when cpu_ready pulses.
module tb_spi_mem_cache;
    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_valid, cpu_ready;
    logic [22:0] cpu_addr;
    logic [31:0] cpu_wdata, cpu_rdata;
    logic [3:0]  cpu_wstrb;
    logic        mem_valid, mem_ready;
    logic [22:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic        flush, flush_a, flush_b;
`ifdef SPI_MEM_CACHE_STATS_EN
    logic [31:0] hit_count, miss_count;
`endif

    assign flush = flush_a | flush_b;

    spi_mem_cache #(.INDEX_BITS(4)) dut (
        .clk(clk), .reset(reset),
        .cpu_valid(cpu_valid), .cpu_ready(cpu_ready), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb), .cpu_rdata(cpu_rdata),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
`ifdef SPI_MEM_CACHE_STATS_EN
        .hit_count(hit_count), .miss_count(miss_count),
`endif
        .flush(flush)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int mem_txns = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Memory model
    logic [31:0] mem_model [logic [22:0]];

    function automatic logic [31:0] mem_rd(input logic [22:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return {9'h0, a} ^ 32'hA5A5_0000;
    endfunction

    // Responder knobs and last-seen request
    int          lat = 3;
    int          hold = 0;
    logic        flush_on_ready = 1'b0;
    logic [22:0] last_addr;
    logic [31:0] last_wdata;
    logic [3:0]  last_wstrb;

    initial begin
        logic [22:0] a;
        logic [31:0] w, m;
        logic [3:0]  s;
        logic        alive;
        mem_ready = 1'b0;
        mem_rdata = '0;
        flush_b   = 1'b0;
        forever begin
            @(negedge clk);
            if (mem_valid && !reset) begin
                a = mem_addr; w = mem_wdata; s = mem_wstrb; alive = 1'b1;
                for (int i = 0; i < lat; i++) begin
                    @(negedge clk);
                    if (!mem_valid) alive = 1'b0;
                end
                if (alive) begin
                    chk("mem_req_stable", {9'h0, mem_addr}, {9'h0, a});
                    last_addr = a; last_wdata = w; last_wstrb = s;
                    if (s == 4'b0000) mem_rdata = mem_rd(a);
                    else begin
                        m = mem_rd(a);
                        for (int b = 0; b < 4; b++) if (s[b]) m[b*8 +: 8] = w[b*8 +: 8];
                        mem_model[a] = m;
                    end
                    mem_ready = 1'b1;
                    flush_b = flush_on_ready;
                    mem_txns++;
                    @(negedge clk);
                    flush_b = 1'b0;
                    chk("mem_valid_drop", {31'h0, mem_valid}, 32'h0);
                    for (int i = 0; i < hold; i++) begin
                        @(negedge clk);
                        chk("mem_valid_drain", {31'h0, mem_valid}, 32'h0);
                    end
                    mem_ready = 1'b0;
                end
            end
        end
    end

    // Scoreboard
    typedef struct {
        logic        is_read;
        logic [31:0] rdata;
        int          txns;
        int          lat;
        int          start;
        int          base;
    } exp_t;

    exp_t sb[$];

    initial begin
        exp_t it;
        forever begin
            @(negedge clk);
            if (cpu_ready) begin
                chk("sb_nonempty", {31'h0, sb.size() != 0}, 32'h1);
                if (sb.size() != 0) begin
                    it = sb.pop_front();
                    if (it.is_read) chk("rdata", cpu_rdata, it.rdata);
                    chk("mem_txns", 32'(mem_txns - it.base), 32'(it.txns));
                    if (it.lat >= 0) chk("hit_latency", 32'(cyc - it.start), 32'(it.lat));
                end
            end
        end
    end

    task automatic cpu_access(input logic [22:0] addr, input logic [31:0] wdata,
                              input logic [3:0] wstrb, input int txns, input int elat,
                              input logic do_flush);
        exp_t it;
        logic seen;
        @(negedge clk);
        it.is_read = (wstrb == 4'b0000);
        it.rdata   = mem_rd(addr);
        it.txns    = txns;
        it.lat     = elat;
        it.start   = cyc;
        it.base    = mem_txns;
        sb.push_back(it);
        cpu_valid = 1'b1; cpu_addr = addr; cpu_wdata = wdata; cpu_wstrb = wstrb;
        flush_a = do_flush;
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            flush_a = 1'b0;
            if (cpu_ready) seen = 1'b1;
        end
        cpu_valid = 1'b0;
        chk("ready_seen", {31'h0, seen}, 32'h1);
    endtask

    task automatic rd(input logic [22:0] addr, input int txns);
        cpu_access(addr, 32'h0, 4'b0000, txns, (txns == 0) ? 1 : -1, 1'b0);
    endtask

    initial begin
        reset = 1'b1; cpu_valid = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        cpu_wstrb = '0; flush_a = 1'b0;
        mem_model[23'h000005] = 32'hDEAD_BEEF;
        repeat (2) @(negedge clk);
        chk("rst_cpu_ready", {31'h0, cpu_ready}, 32'h0);
        chk("rst_mem_valid", {31'h0, mem_valid}, 32'h0);
        chk("rst_cpu_rdata", cpu_rdata, 32'h0);
        chk("rst_mem_addr", {9'h0, mem_addr}, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_mem_wstrb", {28'h0, mem_wstrb}, 32'h0);
        reset = 1'b0;

        // Miss with slow memory, then a 1-cycle hit
        lat = 20;
        rd(23'h000005, 1);
        lat = 3;
        rd(23'h000005, 0);
`ifdef SPI_MEM_CACHE_STATS_EN
        chk("hit_count", hit_count, 32'd1);
        chk("miss_count", miss_count, 32'd1);
`endif

        // Byte write hit, write-through with strobes passed on
        cpu_access(23'h000005, 32'h0000_AA00, 4'b0010, 1, -1, 1'b0);
        chk("mem_wstrb_pass", {28'h0, last_wstrb}, 32'h2);
        chk("mem_wr_addr", {9'h0, last_addr}, 32'h5);
        rd(23'h000005, 0);
        chk("merged_model", mem_rd(23'h000005), 32'hDEAD_AAEF);

        // Same-index eviction
        rd(23'h000015, 1);
        rd(23'h000005, 1);
        rd(23'h000015, 1);

        // Write miss does not allocate; write hit merges lanes 0 and 3
        cpu_access(23'h000040, 32'h1234_5678, 4'b1111, 1, -1, 1'b0);
        rd(23'h000040, 1);
        rd(23'h000040, 0);
        cpu_access(23'h000040, 32'hAABB_CCDD, 4'b1001, 1, -1, 1'b0);
        rd(23'h000040, 0);

        // Flush together with an accepted request forces a miss
        cpu_access(23'h000040, 32'h0, 4'b0000, 1, -1, 1'b1);

        // Flush on the fill edge: data still returned, line not filled
        flush_on_ready = 1'b1;
        rd(23'h000022, 1);
        flush_on_ready = 1'b0;
        rd(23'h000022, 1);
        rd(23'h000040, 1);

        // mem_ready held after the handshake; zero-latency memory
        hold = 3;
        rd(23'h000033, 1);
        hold = 0;
        lat = 0;
        rd(23'h000034, 1);
        rd(23'h000034, 0);
        lat = 3;

        // Reset while in MEM_REQ
        lat = 40;
        @(negedge clk);
        cpu_valid = 1'b1; cpu_addr = 23'h000007; cpu_wstrb = 4'b0000;
        repeat (5) @(negedge clk);
        chk("abort_mem_valid_pre", {31'h0, mem_valid}, 32'h1);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_mem_valid", {31'h0, mem_valid}, 32'h0);
        chk("abort_cpu_ready", {31'h0, cpu_ready}, 32'h0);
`ifdef SPI_MEM_CACHE_STATS_EN
        chk("abort_hit_count", hit_count, 32'd0);
        chk("abort_miss_count", miss_count, 32'd0);
`endif
        reset = 1'b0; cpu_valid = 1'b0;
        repeat (50) @(negedge clk);
        lat = 3;
        rd(23'h000034, 1);
        rd(23'h000022, 1);

        repeat (5) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
